// File: rtl/rbm_input_loader_pkg.sv
// Shared configuration for the RBM input loader: pixel width, image sizes,
// FSM encoding and the packing layout that Main's unpack expects.
`timescale 1ns/1ps
package rbm_input_loader_pkg;

    localparam int DEFAULT_BITLENGTH = 12;
    localparam int GENERAL_INPUT_DIM = 784;
    localparam int SPARSE_INPUT_DIM  = 64;
    localparam bit SPARSE_BUILD      = 1'b0;
    localparam int DEFAULT_INPUT_DIM = SPARSE_BUILD ? SPARSE_INPUT_DIM : GENERAL_INPUT_DIM;

    typedef enum logic [1:0] {
        RECOVER = 2'd0,
        FILL    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Word i of the packed image sits at bits [i*width +: width].
    function automatic int word_lsb(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/rbm_input_loader.sv
// Streams pixels into Main's packed InputDataPort, presents a full image with
// data_valid, and resets Main between images on its finish edge.
`timescale 1ns/1ps
module rbm_input_loader
    import rbm_input_loader_pkg::*;
#(
    parameter int bitlength    = DEFAULT_BITLENGTH,
    parameter int input_dim    = DEFAULT_INPUT_DIM,
    parameter int reset_cycles = 3,
    parameter int count_width  = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [bitlength-1:0]           pixel_in,
    input  logic                           pixel_valid,
    input  logic                           pixel_last,
    output logic                           pixel_ready,
    output logic [input_dim*bitlength-1:0] InputDataPort,
    output logic                           data_valid,
    output logic                           rbm_reset,
    input  logic                           main_finish,
    output logic                           frame_error,
    output logic [count_width-1:0]         image_count,
    output state_t                         state_dbg
);

    localparam int IDX_W = (input_dim > 1) ? $clog2(input_dim) : 1;
    localparam int RST_W = (reset_cycles > 1) ? $clog2(reset_cycles) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(input_dim - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(reset_cycles - 1);

    // Handshake: a pixel moves only in a cycle where pixel_valid && pixel_ready;
    // the source must hold pixel_in/pixel_last stable until then.
    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [RST_W-1:0]   rst_cnt;
    logic               finish_q;
    logic               beat;
    logic               finish_rise;

    assign beat        = pixel_valid && pixel_ready && !reset;
    assign finish_rise = main_finish && !finish_q;
    assign state_dbg   = state;

    always_comb begin
        state_next  = state;
        pixel_ready = 1'b0;
        unique case (state)
            RECOVER: begin
                if (rst_cnt == RST_LAST) state_next = FILL;
            end
            FILL: begin
                pixel_ready = 1'b1;
                if (pixel_valid && idx == IDX_LAST) state_next = HOLD;
            end
            HOLD: begin
                if (finish_rise) state_next = RECOVER;
            end
            default: state_next = RECOVER;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RECOVER;
            rst_cnt     <= '0;
            idx         <= '0;
            data_valid  <= 1'b0;
            rbm_reset   <= 1'b1;
            frame_error <= 1'b0;
            image_count <= '0;
            finish_q    <= 1'b0;
        end else begin
            state       <= state_next;
            finish_q    <= main_finish;
            frame_error <= 1'b0;
            unique case (state)
                RECOVER: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt   <= '0;
                        rbm_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                FILL: begin
                    if (beat) begin
                        // Length is authoritative: a missing last still completes the image.
                        if (idx == IDX_LAST) begin
                            idx         <= '0;
                            data_valid  <= 1'b1;
                            frame_error <= !pixel_last;
                        end else if (pixel_last) begin
                            idx         <= '0;
                            frame_error <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (finish_rise) begin
                        data_valid  <= 1'b0;
                        image_count <= image_count + count_width'(1);
                        rbm_reset   <= 1'b1;
                        rst_cnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Image storage is never cleared; only written words matter once data_valid rises.
    always_ff @(posedge clock) begin
        if (beat) begin
            InputDataPort[word_lsb(int'(idx), bitlength) +: bitlength] <= pixel_in;
        end
    end

endmodule

// File: tb/tb_rbm_input_loader.sv
// Directed sequence with random pixel data; expected images come from a queue of
// every pixel the bench handed over, and timing from the loader's documented rules.
`timescale 1ns/1ps
module tb_rbm_input_loader;
    import rbm_input_loader_pkg::*;

    localparam int BL  = 12;
    localparam int DIM = 784;
    localparam int RC  = 3;
    localparam int CW  = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [BL-1:0]       pixel_in;
    logic                pixel_valid;
    logic                pixel_last;
    logic                pixel_ready;
    logic [DIM*BL-1:0]   InputDataPort;
    logic                data_valid;
    logic                rbm_reset;
    logic                main_finish;
    logic                frame_error;
    logic [CW-1:0]       image_count;
    state_t              state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_seen = 0;
    int fe_exp = 0;
    int exp_count = 0;
    logic [BL-1:0] exp_q[$];
    logic [BL-1:0] prev_q[$];

    rbm_input_loader #(
        .bitlength(BL), .input_dim(DIM), .reset_cycles(RC), .count_width(CW)
    ) dut (
        .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_last(pixel_last), .pixel_ready(pixel_ready), .InputDataPort(InputDataPort),
        .data_valid(data_valid), .rbm_reset(rbm_reset), .main_finish(main_finish),
        .frame_error(frame_error), .image_count(image_count), .state_dbg(state_dbg)
    );

    // Clock and cycle/pulse monitors
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;
    always @(negedge clock) if (frame_error === 1'b1) fe_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_image(input string tag);
        logic [DIM*BL-1:0] exp_port;
        int bad;
        exp_port = '0;
        for (int i = 0; i < DIM; i++) exp_port[i*BL +: BL] = exp_q[i];
        checks++;
        assert (InputDataPort === exp_port) else begin
            errors++;
            bad = -1;
            for (int i = 0; i < DIM; i++)
                if (bad < 0 && InputDataPort[i*BL +: BL] !== exp_port[i*BL +: BL]) bad = i;
            $error("FAIL %s word=%0d observed=%0h expected=%0h", tag, bad,
                   InputDataPort[bad*BL +: BL], exp_port[bad*BL +: BL]);
        end
    endtask

    // Driver: present one pixel and return #1 after the edge that accepts it.
    task automatic send_beat(input logic [BL-1:0] pix, input logic last);
        int w;
        w = 0;
        pixel_in    = pix;
        pixel_last  = last;
        pixel_valid = 1'b1;
        while (pixel_ready !== 1'b1 && w < 50) begin
            @(posedge clock); #1;
            w++;
        end
        check("beat_ready", pixel_ready, 1);
        @(posedge clock); #1;
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
    endtask

    // mode 0: ramp i mod 4096, 1: random, 2: replay previous image
    task automatic load_image(input int mode, input bit with_last, input bit gap,
                              output int elapsed);
        logic [BL-1:0] pix;
        int start;
        prev_q = exp_q;
        exp_q.delete();
        start = cyc;
        for (int i = 0; i < DIM; i++) begin
            case (mode)
                0:       pix = BL'(i % 4096);
                1:       pix = BL'($urandom_range(0, 4095));
                default: pix = prev_q[i];
            endcase
            exp_q.push_back(pix);
            if (gap) begin
                pixel_valid = 1'b0;
                @(posedge clock); #1;
            end
            if (i == DIM - 1) check("dv_before_last", data_valid, 0);
            send_beat(pix, with_last && (i == DIM - 1));
        end
        elapsed = cyc - start;
        check("dv_after_last", data_valid, 1);
        check("ready_in_hold", pixel_ready, 0);
        check("fe_at_last", frame_error, with_last ? 0 : 1);
        if (!with_last) fe_exp++;
        check_image("image");
    endtask

    // From a sample where rbm_reset is already high, count its high cycles.
    task automatic wait_recovery(input string tag);
        int hi;
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (rbm_reset === 1'b1) hi++;
            else break;
        end
        check({tag, "_rst_len"}, hi, RC);
        check({tag, "_ready_after"}, pixel_ready, 1);
        check({tag, "_dv_low"}, data_valid, 0);
    endtask

    task automatic finish_image(input int hold);
        int done;
        main_finish = 1'b1;
        @(posedge clock); #1;
        exp_count = (exp_count + 1) % (1 << CW);
        check("fin_dv_fall", data_valid, 0);
        check("fin_rst_rise", rbm_reset, 1);
        check("fin_count", image_count, exp_count);
        done = cyc;
        wait_recovery("fin");
        done = cyc - done;
        repeat ((hold - 1 - done) > 0 ? (hold - 1 - done) : 0) @(posedge clock);
        #1;
        main_finish = 1'b0;
        @(posedge clock); #1;
        check("fin_count_stable", image_count, exp_count);
        check("fin_still_fill", pixel_ready, 1);
    endtask

    initial begin
        int el;
        reset = 1'b1; pixel_valid = 1'b0; pixel_last = 1'b0; pixel_in = '0; main_finish = 1'b0;

        // 1. reset and recovery
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_rbm_reset", rbm_reset, 1);
        check("rst_dv", data_valid, 0);
        check("rst_count", image_count, 0);
        check("rst_ready", pixel_ready, 0);
        check("rst_fe", frame_error, 0);
        wait_recovery("init");

        // 2. ramp image, then hold with pixel_valid asserted
        load_image(0, 1'b1, 1'b0, el);
        check("ramp_latency", el, DIM);
        pixel_valid = 1'b1;
        pixel_in = BL'($urandom_range(0, 4095));
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check("hold_ready", pixel_ready, 0);
        end
        pixel_valid = 1'b0;
        check("hold_dv", data_valid, 1);
        check_image("hold_frozen");

        // 3. finish held 5 cycles counts once
        finish_image(5);

        // 4. early last, stray finish in FILL, then a full image
        for (int i = 0; i <= 10; i++) send_beat(BL'($urandom_range(0, 4095)), i == 10);
        check("early_fe", frame_error, 1);
        check("early_dv", data_valid, 0);
        fe_exp++;
        main_finish = 1'b1;
        @(posedge clock); #1;
        main_finish = 1'b0;
        @(posedge clock); #1;
        check("fill_finish_ignored", image_count, exp_count);
        load_image(1, 1'b1, 1'b0, el);
        finish_image(1);

        // 5a. no last; finish stuck high from before HOLD must not count
        main_finish = 1'b1;
        load_image(1, 1'b0, 1'b0, el);
        repeat (3) @(posedge clock);
        #1;
        check("stuck_dv", data_valid, 1);
        check("stuck_count", image_count, exp_count);
        main_finish = 1'b0;
        @(posedge clock); #1;
        finish_image(2);

        // 5b. same contents with pixel_valid toggling
        load_image(2, 1'b0, 1'b1, el);
        check("gap_latency", el, 2 * DIM);
        finish_image(1);

        // 6. reset after 400 beats
        for (int i = 0; i < 400; i++) send_beat(BL'($urandom_range(0, 4095)), 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_count = 0;
        check("mid_rst_rbm", rbm_reset, 1);
        check("mid_rst_count", image_count, 0);
        check("mid_rst_ready", pixel_ready, 0);
        wait_recovery("mid");
        load_image(1, 1'b1, 1'b0, el);
        check("mid_count_before_fin", image_count, 0);
        finish_image(1);

        repeat (2) @(posedge clock);
        check("fe_pulses", fe_seen, fe_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
